// File: rtl/mvu_pe_acc_ctrl.sv
// Accumulation and handshake controller for one MVU processing element.
// Each accepted beat carries a {valid, first, last} tag through the adder-tree latency.
module mvu_pe_acc_ctrl #(
    parameter int SF       = 4,
    parameter int NF       = 2,
    parameter int PIPE_LAT = 2,
    parameter int TDstI    = 16,
    parameter int ACC_W    = TDstI + $clog2(SF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    output logic             in_rdy,
    input  logic [TDstI-1:0] add_out,
    output logic             out_v,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);
    localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic [1:0] {StIdle, StAcc, StWait, StHold} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SF_W-1:0]  r_sf_cnt;
    logic [NF_W-1:0]  r_nf_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_tag [PIPE_LAT];
    logic             r_out_v;
    logic [ACC_W-1:0] r_out_data;

    logic             w_in_rdy;
    logic             w_accept;
    logic             w_sf_first;
    logic             w_sf_last;
    logic             w_out_hs;
    logic             w_tag_v;
    logic             w_tag_first;
    logic             w_tag_last;
    logic [ACC_W-1:0] w_add_ext;
    logic [ACC_W-1:0] w_sum;

    assign w_sf_first = (r_sf_cnt == '0);
    assign w_sf_last  = (r_sf_cnt == SF_W'(SF - 1));
    assign w_in_rdy   = !rst && ((r_state == StIdle) || (r_state == StAcc) ||
                                 ((r_state == StHold) && out_rdy));
    assign w_accept   = in_v && w_in_rdy;
    assign w_out_hs   = r_out_v && out_rdy;

    // The tag leaving the last stage lines up with the current add_out.
    assign {w_tag_v, w_tag_first, w_tag_last} = r_tag[PIPE_LAT-1];
    assign w_add_ext = ACC_W'(add_out);
    assign w_sum     = w_tag_first ? w_add_ext : r_acc + w_add_ext;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_nxt = (SF > 1) ? StAcc : StWait;
            end
            StAcc: begin
                if (w_accept && w_sf_last) w_state_nxt = StWait;
            end
            StWait: begin
                if (w_tag_v && w_tag_last) w_state_nxt = StHold;
            end
            StHold: begin
                if (out_rdy) begin
                    if (w_accept) w_state_nxt = (SF > 1) ? StAcc : StWait;
                    else          w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_sf_cnt   <= '0;
            r_nf_cnt   <= '0;
            r_acc      <= '0;
            r_out_v    <= 1'b0;
            r_out_data <= '0;
            for (int i = 0; i < PIPE_LAT; i++) r_tag[i] <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_sf_cnt <= w_sf_last ? '0 : r_sf_cnt + 1'b1;
            if (w_out_hs) r_nf_cnt <= (r_nf_cnt == NF_W'(NF - 1)) ? '0 : r_nf_cnt + 1'b1;
            r_tag[0] <= {w_accept, w_accept && w_sf_first, w_accept && w_sf_last};
            for (int i = 1; i < PIPE_LAT; i++) r_tag[i] <= r_tag[i-1];
            if (w_tag_v) r_acc <= w_sum;
            // A new result only lands in WAIT, so it never collides with a handshake.
            if (w_tag_v && w_tag_last) begin
                r_out_v    <= 1'b1;
                r_out_data <= w_sum;
            end else if (w_out_hs) begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign in_rdy   = w_in_rdy;
    assign out_v    = r_out_v;
    assign out_data = r_out_data;
    assign out_last = r_out_v && (r_nf_cnt == NF_W'(NF - 1));

endmodule
